// File: rtl/spatial_encoder.sv
// Encodes one multi-channel feature word into a bundled spatial hypervector:
// each channel's level vector is bound to a rotated ID vector, then majority-bundled.
module spatial_encoder #(
  parameter int INPUT_CHANNELS = 4,
  parameter int CHANNEL_WIDTH  = 6,
  parameter int HV_DIMENSION   = 1024,
  parameter int MODE_WIDTH     = 2,
  parameter int LABEL_WIDTH    = 4,
  parameter logic [HV_DIMENSION-1:0] LEVEL_SEED = '0,
  parameter logic [HV_DIMENSION-1:0] ID_SEED    = '0
) (
  input  logic                                    Clk_CI,
  input  logic                                    Reset_RI,
  input  logic                                    ValidIn_SI,
  output logic                                    ReadyOut_SO,
  input  logic [MODE_WIDTH-1:0]                   ModeIn_SI,
  input  logic [LABEL_WIDTH-1:0]                  LabelIn_DI,
  input  logic [CHANNEL_WIDTH*INPUT_CHANNELS-1:0] ChannelsIn_DI,
  output logic                                    ValidOut_SO,
  input  logic                                    ReadyIn_SI,
  output logic [MODE_WIDTH-1:0]                   ModeOut_SO,
  output logic [LABEL_WIDTH-1:0]                  LabelOut_DO,
  output logic [HV_DIMENSION-1:0]                 HypervectorOut_DO
);

  localparam int CNT_W = $clog2(INPUT_CHANNELS + 1);
  localparam int IDX_W = (INPUT_CHANNELS > 1) ? $clog2(INPUT_CHANNELS) : 1;
  localparam int FW    = CHANNEL_WIDTH + $clog2(HV_DIMENSION) + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    OUTPUT = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_accept;
  logic   w_accum;
  logic   w_last_ch;

  logic [CHANNEL_WIDTH*INPUT_CHANNELS-1:0] r_chans;
  logic [MODE_WIDTH-1:0]                   r_mode;
  logic [LABEL_WIDTH-1:0]                  r_label;
  logic [IDX_W-1:0]                        r_idx;
  logic [HV_DIMENSION-1:0]                 r_tie;
  logic [CNT_W-1:0]                        r_cnt [HV_DIMENSION];
  logic [HV_DIMENSION-1:0]                 r_hv;
  logic [MODE_WIDTH-1:0]                   r_mode_out;
  logic [LABEL_WIDTH-1:0]                  r_label_out;

  logic [CHANNEL_WIDTH-1:0] w_chan;
  logic [FW-1:0]            w_prod;
  logic [FW-1:0]            w_flip;
  logic [HV_DIMENSION-1:0]  w_level;
  logic [HV_DIMENSION-1:0]  w_id;
  logic [HV_DIMENSION-1:0]  w_bound;
  logic [HV_DIMENSION-1:0]  w_tie;
  logic [HV_DIMENSION-1:0]  w_major;
  logic [CNT_W-1:0]         w_cnt_nxt [HV_DIMENSION];

  always_ff @(posedge Clk_CI) begin
    if (Reset_RI) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = IDLE;
    ReadyOut_SO = 1'b0;
    ValidOut_SO = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        ReadyOut_SO = 1'b1;
        if (ValidIn_SI) begin
          w_accept    = 1'b1;
          w_state_nxt = ACCUM;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      ACCUM:   w_state_nxt = w_last_ch ? OUTPUT : ACCUM;
      OUTPUT: begin
        ValidOut_SO = 1'b1;
        w_state_nxt = ReadyIn_SI ? IDLE : OUTPUT;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_accum   = (r_state == ACCUM);
  assign w_last_ch = (r_idx == IDX_W'(INPUT_CHANNELS - 1));

  // Level vector flips the lowest F(v) seed bits; F(v) = v*D >> (CW+1).
  assign w_chan = r_chans[r_idx*CHANNEL_WIDTH +: CHANNEL_WIDTH];
  assign w_prod = FW'(w_chan) * FW'(HV_DIMENSION);
  assign w_flip = w_prod >> (CHANNEL_WIDTH + 1);
  assign w_id   = (ID_SEED << r_idx) | (ID_SEED >> (HV_DIMENSION - int'(r_idx)));
  assign w_bound = w_level ^ w_id;
  assign w_tie   = (r_idx == '0) ? w_bound : r_tie;

  for (genvar k = 0; k < HV_DIMENSION; k++) begin : g_bit
    logic [CNT_W:0] w_twice;
    assign w_level[k]   = (FW'(k) < w_flip) ? ~LEVEL_SEED[k] : LEVEL_SEED[k];
    assign w_cnt_nxt[k] = r_cnt[k] + CNT_W'(w_bound[k]);
    assign w_twice      = {w_cnt_nxt[k], 1'b0};
    assign w_major[k]   = (w_twice > (CNT_W+1)'(INPUT_CHANNELS)) ? 1'b1 :
                          (w_twice < (CNT_W+1)'(INPUT_CHANNELS)) ? 1'b0 : w_tie[k];
  end

  always_ff @(posedge Clk_CI) begin
    if (Reset_RI) begin
      r_chans     <= '0;
      r_mode      <= '0;
      r_label     <= '0;
      r_idx       <= '0;
      r_tie       <= '0;
      r_hv        <= '0;
      r_mode_out  <= '0;
      r_label_out <= '0;
      for (int k = 0; k < HV_DIMENSION; k++) r_cnt[k] <= '0;
    end else if (w_accept) begin
      r_chans <= ChannelsIn_DI;
      r_mode  <= ModeIn_SI;
      r_label <= LabelIn_DI;
      r_idx   <= '0;
      for (int k = 0; k < HV_DIMENSION; k++) r_cnt[k] <= '0;
    end else if (w_accum) begin
      r_idx <= r_idx + IDX_W'(1);
      for (int k = 0; k < HV_DIMENSION; k++) r_cnt[k] <= w_cnt_nxt[k];
      if (r_idx == '0) r_tie <= w_bound;
      // Final channel: bundle includes this cycle's contribution.
      if (w_last_ch) begin
        r_hv        <= w_major;
        r_mode_out  <= r_mode;
        r_label_out <= r_label;
      end
    end
  end

  assign HypervectorOut_DO = r_hv;
  assign ModeOut_SO        = r_mode_out;
  assign LabelOut_DO       = r_label_out;

endmodule

// File: tb/tb_spatial_encoder.sv
// Directed checks of spatial_encoder with zero seeds: reset, latency, bundling, ties, backpressure, mid-op reset.
module tb_spatial_encoder;

  localparam int IC = 4;
  localparam int CW = 6;
  localparam int D  = 1024;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          vin = 1'b0;
  logic          rdy_out;
  logic [1:0]    mode_in = '0;
  logic [3:0]    label_in = '0;
  logic [CW*IC-1:0] ch_in = '0;
  logic          vout;
  logic          rdy_in = 1'b0;
  logic [1:0]    mode_out;
  logic [3:0]    label_out;
  logic [D-1:0]  hv_out;

  int n_vec = 0;
  int n_err = 0;

  spatial_encoder #(
    .INPUT_CHANNELS(IC), .CHANNEL_WIDTH(CW), .HV_DIMENSION(D),
    .MODE_WIDTH(2), .LABEL_WIDTH(4), .LEVEL_SEED('0), .ID_SEED('0)
  ) dut (
    .Clk_CI(clk), .Reset_RI(rst), .ValidIn_SI(vin), .ReadyOut_SO(rdy_out),
    .ModeIn_SI(mode_in), .LabelIn_DI(label_in), .ChannelsIn_DI(ch_in),
    .ValidOut_SO(vout), .ReadyIn_SI(rdy_in), .ModeOut_SO(mode_out),
    .LabelOut_DO(label_out), .HypervectorOut_DO(hv_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_hv(input string tag, input logic [D-1:0] obs, input logic [D-1:0] exp);
    int first;
    first = -1;
    for (int i = D - 1; i >= 0; i--) if (obs[i] !== exp[i]) first = i;
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed ones=%0d expected ones=%0d first differing bit=%0d",
             tag, $countones(obs), $countones(exp), first);
    end
  endtask

  function automatic logic [D-1:0] low_ones(input int n);
    logic [D-1:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [CW*IC-1:0] pack(input int c0, input int c1, input int c2, input int c3);
    return {CW'(c3), CW'(c2), CW'(c1), CW'(c0)};
  endfunction

  // Accepts one word and walks the ACCUM cycles; returns in the first OUTPUT cycle.
  task automatic run_sample(input logic [CW*IC-1:0] ch, input logic [1:0] m, input logic [3:0] l);
    vin = 1'b1; ch_in = ch; mode_in = m; label_in = l;
    step();
    vin = 1'b0; ch_in = ~ch; mode_in = ~m; label_in = ~l;
    chk("accum_ready_low", 32'(rdy_out), 32'd0);
    for (int i = 0; i < IC - 1; i++) begin
      step();
      chk("accum_valid_low", 32'(vout), 32'd0);
    end
    step();
    chk("latency_valid", 32'(vout), 32'd1);
    chk("output_ready_low", 32'(rdy_out), 32'd0);
  endtask

  task automatic release_output();
    rdy_in = 1'b1;
    step();
    rdy_in = 1'b0;
    chk("idle_valid_low", 32'(vout), 32'd0);
    chk("idle_ready_high", 32'(rdy_out), 32'd1);
  endtask

  initial begin
    logic [D-1:0] held;

    // Reset held for two edges.
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("rst_valid", 32'(vout), 32'd0);
    chk("rst_ready", 32'(rdy_out), 32'd1);
    chk_hv("rst_hv", hv_out, '0);
    chk("rst_mode", 32'(mode_out), 32'd0);
    chk("rst_label", 32'(label_out), 32'd0);

    // All channels at 63: F=504 everywhere.
    run_sample(pack(63, 63, 63, 63), 2'd1, 4'd3);
    chk_hv("all63_hv", hv_out, low_ones(504));
    chk("all63_mode", 32'(mode_out), 32'd1);
    chk("all63_label", 32'(label_out), 32'd3);
    release_output();

    // Two-vs-two tie resolved by channel 0's bound vector.
    run_sample(pack(63, 63, 0, 0), 2'd2, 4'd7);
    chk_hv("tie_hv", hv_out, low_ones(504));
    chk("tie_mode", 32'(mode_out), 32'd2);
    release_output();

    // F = 504, 256, 0, 0.
    run_sample(pack(63, 32, 0, 0), 2'd0, 4'd9);
    chk_hv("mixed_hv", hv_out, low_ones(256));
    chk("mixed_label", 32'(label_out), 32'd9);
    release_output();

    // F = 80,160,240,320: bits 160..239 tie with T=0 there.
    run_sample(pack(10, 20, 30, 40), 2'd3, 4'd12);
    chk_hv("stair_hv", hv_out, low_ones(160));
    release_output();

    // Single small channel is a minority everywhere.
    run_sample(pack(1, 0, 0, 0), 2'd1, 4'd1);
    chk_hv("minority_hv", hv_out, '0);
    release_output();

    // Backpressure: outputs hold, new data ignored.
    run_sample(pack(63, 32, 0, 0), 2'd2, 4'd6);
    held = hv_out;
    chk_hv("bp_initial_hv", held, low_ones(256));
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin vin = 1'b1; ch_in = pack(63, 63, 63, 63); mode_in = 2'd1; label_in = 4'd15; end
      if (i == 5) vin = 1'b0;
      step();
      chk("bp_valid", 32'(vout), 32'd1);
      chk("bp_ready", 32'(rdy_out), 32'd0);
      chk_hv("bp_hv", hv_out, low_ones(256));
      chk("bp_label", 32'(label_out), 32'd6);
    end
    // Valid alongside ReadyIn in OUTPUT must not start a sample.
    vin = 1'b1; ch_in = pack(63, 63, 63, 63);
    rdy_in = 1'b1;
    step();
    vin = 1'b0; rdy_in = 1'b0;
    chk("bp_exit_valid", 32'(vout), 32'd0);
    chk("bp_exit_ready", 32'(rdy_out), 32'd1);
    step();
    chk("bp_not_accepted", 32'(rdy_out), 32'd1);
    chk_hv("bp_hv_kept", hv_out, low_ones(256));

    // Reset during the second ACCUM cycle discards the sample.
    rdy_in = 1'b1;
    vin = 1'b1; ch_in = pack(63, 63, 63, 63); mode_in = 2'd3; label_in = 4'd10;
    step();
    vin = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_valid", 32'(vout), 32'd0);
    chk("midrst_ready", 32'(rdy_out), 32'd1);
    chk_hv("midrst_hv", hv_out, '0);
    chk("midrst_mode", 32'(mode_out), 32'd0);
    chk("midrst_label", 32'(label_out), 32'd0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("midrst_no_pulse", 32'(vout), 32'd0);
    end
    rdy_in = 1'b0;
    run_sample(pack(63, 32, 0, 0), 2'd2, 4'd5);
    chk_hv("post_rst_hv", hv_out, low_ones(256));
    chk("post_rst_mode", 32'(mode_out), 32'd2);
    chk("post_rst_label", 32'(label_out), 32'd5);
    release_output();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
